// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array datapath.
// Holds the default element format (Q5.10 in a 16-bit word), the
// fixed-point word type and the state encoding of the skew feeder.
package systolic_pkg;

  localparam int WIDTH    = 16;
  localparam int FRAC_BIT = 10;

  typedef logic [WIDTH-1:0] fx_word_t;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/feeder_buf.sv
// Burst buffer for the skew feeder: DEPTH entries of one full activation
// vector (ROWS elements) each.
//   clk      : write clock
//   wr_en    : write strobe
//   wr_addr  : entry to write
//   wr_data  : full vector to store
//   rd_addr  : per-row entry index, row r at [r*A_W +: A_W]
//   rd_en    : per-row in-window flag; out-of-window rows read as zero
//   rd_data  : row r returns element r of entry rd_addr[r]
// Storage has no reset: contents are only meaningful after being written.
module feeder_buf #(
  parameter int WIDTH = 16,
  parameter int ROWS  = 2,
  parameter int DEPTH = 4,
  parameter int A_W   = 2
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [A_W-1:0]        wr_addr,
  input  logic [ROWS*WIDTH-1:0] wr_data,
  input  logic [ROWS*A_W-1:0]   rd_addr,
  input  logic [ROWS-1:0]       rd_en,
  output logic [ROWS*WIDTH-1:0] rd_data
);

  logic [ROWS*WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_rd
    assign rd_data[r*WIDTH +: WIDTH] =
      rd_en[r] ? mem[rd_addr[r*A_W +: A_W]][r*WIDTH +: WIDTH] : '0;
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skew feeder in front of the systolic array. Collects a burst of column
// vectors from a valid/ready producer, then replays it diagonally: row r
// is delayed r steps and zero outside its window.
//   clk, rst  : clock, asynchronous active-high reset
//   in_valid  : producer has a vector       in_ready : feeder accepts (LOAD)
//   in_data   : vector, element r at [r*WIDTH +: WIDTH]
//   in_last   : final vector of the burst
//   stall     : downstream hold while streaming
//   a_out     : skewed row data, row r at [r*WIDTH +: WIDTH]
//   a_valid   : per-row valid for a_out
//   busy      : streaming or finishing       done : one-cycle end-of-burst pulse
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int FRAC_BIT = 10,
  parameter int ROWS     = 2,
  parameter int DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROWS*WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  stall,
  output logic [ROWS*WIDTH-1:0] a_out,
  output logic [ROWS-1:0]       a_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int A_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int C_W = $clog2(DEPTH + 1);
  localparam int T_W = $clog2(DEPTH + ROWS);

  if (FRAC_BIT < 0 || FRAC_BIT >= WIDTH) begin : g_bad_frac
    $error("FRAC_BIT must lie in [0, WIDTH-1]");
  end

  feeder_state_t         state_q, state_d;
  logic [C_W-1:0]        count_q;
  logic [T_W-1:0]        t_q;
  logic                  accept, last_beat, stream_end;
  logic [ROWS*A_W-1:0]   rd_addr;
  logic [ROWS-1:0]       rd_en;
  logic [ROWS*WIDTH-1:0] rd_data;
  logic [ROWS*WIDTH-1:0] load_data;

  assign in_ready   = (state_q == LOAD);
  assign busy       = (state_q != LOAD);
  assign accept     = in_valid & in_ready;
  assign last_beat  = accept & (in_last | (count_q == C_W'(DEPTH - 1)));
  // t_q is the next step to load; once it passes count+ROWS-2 every step is out.
  assign stream_end = (t_q == T_W'(count_q) + T_W'(ROWS - 1));

  // Row r reads entry t-r; the extra top bit catches t<r as a borrow.
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic [T_W:0] idx;
    assign idx = {1'b0, t_q} - (T_W + 1)'(r);
    assign rd_en[r] = !idx[T_W] && (idx[T_W-1:0] < T_W'(count_q));
    assign rd_addr[r*A_W +: A_W] = idx[A_W-1:0];
  end

  feeder_buf #(
    .WIDTH (WIDTH),
    .ROWS  (ROWS),
    .DEPTH (DEPTH),
    .A_W   (A_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (count_q[A_W-1:0]),
    .wr_data (in_data),
    .rd_addr (rd_addr),
    .rd_en   (rd_en),
    .rd_data (rd_data)
  );

  // Step 0 is loaded on the edge accepting the last beat. Only row 0 is in
  // window then; for a one-vector burst that entry is still on in_data.
  always_comb begin
    load_data = rd_data;
    if (count_q == '0) load_data[WIDTH-1:0] = in_data[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (last_beat) state_d = STREAM;
      STREAM:  if (!stall && stream_end) state_d = DONE;
      DONE:    state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  // ---- output stage: registered skewed step ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      t_q     <= '0;
      a_out   <= '0;
      a_valid <= '0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (accept) count_q <= count_q + 1'b1;
          if (last_beat) begin
            a_out   <= load_data;
            a_valid <= ROWS'(1);
            t_q     <= T_W'(1);
          end
        end
        STREAM: begin
          if (!stall) begin
            if (stream_end) begin
              a_out   <= '0;
              a_valid <= '0;
              done    <= 1'b1;
            end else begin
              a_out   <= rd_data;
              a_valid <= rd_en;
              t_q     <= t_q + 1'b1;
            end
          end
        end
        DONE: begin
          done    <= 1'b0;
          count_q <= '0;
          t_q     <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder at ROWS=2, DEPTH=4, WIDTH=16.
// Observed bus: {a_out row1, a_out row0, a_valid, done, busy, in_ready}.
module tb_systolic_skew_feeder;
  import systolic_pkg::*;

  localparam int ROWS  = 2;
  localparam int DEPTH = 4;
  localparam fx_word_t Z = 16'h0000;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [ROWS*WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  stall;
  logic [ROWS*WIDTH-1:0] a_out;
  logic [ROWS-1:0]       a_valid;
  logic                  busy;
  logic                  done;
  logic [36:0]           obs;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign obs = {a_out, a_valid, done, busy, in_ready};

  systolic_skew_feeder #(
    .WIDTH    (WIDTH),
    .FRAC_BIT (FRAC_BIT),
    .ROWS     (ROWS),
    .DEPTH    (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .stall    (stall),
    .a_out    (a_out),
    .a_valid  (a_valid),
    .busy     (busy),
    .done     (done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [36:0] ex(input fx_word_t r1, input fx_word_t r0,
                                     input logic [1:0] v, input logic d,
                                     input logic b, input logic rdy);
    return {r1, r0, v, d, b, rdy};
  endfunction

  task automatic send(input fx_word_t r1, input fx_word_t r0, input logic last);
    in_valid = 1'b1;
    in_data  = {r1, r0};
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 32'hDEAD_BEEF;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; stall = 1'b0; in_data = '0;
    tick(); tick();
    if (obs !== ex(Z, Z, 2'b00, 1'b0, 1'b0, 1'b1)) begin
      n_bad++; $display("FAIL reset_held: got %h want %h", obs, ex(Z, Z, 2'b00, 1'b0, 1'b0, 1'b1));
    end
    n_cmp++;
    rst = 1'b0;
    tick();
    if (obs !== ex(Z, Z, 2'b00, 1'b0, 1'b0, 1'b1)) begin
      n_bad++; $display("FAIL reset_released: got %h want %h", obs, ex(Z, Z, 2'b00, 1'b0, 1'b0, 1'b1));
    end
    n_cmp++;
  endtask

  task automatic test_basic;
    logic [36:0] e[$];
    send(16'h0800, 16'h0400, 1'b0);
    send(16'h1000, 16'h0C00, 1'b1);
    e = '{ex(Z, 16'h0400, 2'b01, 1'b0, 1'b1, 1'b0),
          ex(16'h0800, 16'h0C00, 2'b11, 1'b0, 1'b1, 1'b0),
          ex(16'h1000, Z, 2'b10, 1'b0, 1'b1, 1'b0),
          ex(Z, Z, 2'b00, 1'b1, 1'b1, 1'b0),
          ex(Z, Z, 2'b00, 1'b0, 1'b0, 1'b1)};
    foreach (e[i]) begin
      if (obs !== e[i]) begin
        n_bad++; $display("FAIL basic step%0d: got %h want %h", i, obs, e[i]);
      end
      n_cmp++;
      tick();
    end
  endtask

  task automatic test_full;
    logic [36:0] e[$];
    for (int k = 0; k < DEPTH; k++)
      send(16'h2200 + 16'(k), 16'h1100 + 16'(k), 1'b0);
    // A fifth vector waits on the bus for the whole stream.
    in_valid = 1'b1;
    in_data  = {16'h7777, 16'h6666};
    e = '{ex(Z, 16'h1100, 2'b01, 1'b0, 1'b1, 1'b0),
          ex(16'h2200, 16'h1101, 2'b11, 1'b0, 1'b1, 1'b0),
          ex(16'h2201, 16'h1102, 2'b11, 1'b0, 1'b1, 1'b0),
          ex(16'h2202, 16'h1103, 2'b11, 1'b0, 1'b1, 1'b0),
          ex(16'h2203, Z, 2'b10, 1'b0, 1'b1, 1'b0),
          ex(Z, Z, 2'b00, 1'b1, 1'b1, 1'b0),
          ex(Z, Z, 2'b00, 1'b0, 1'b0, 1'b1)};
    foreach (e[i]) begin
      if (obs !== e[i]) begin
        n_bad++; $display("FAIL full step%0d: got %h want %h", i, obs, e[i]);
      end
      n_cmp++;
      if (i == 5) in_valid = 1'b0;
      tick();
    end
  endtask

  task automatic test_stall;
    logic [36:0] e[$];
    send(16'h0800, 16'h0400, 1'b0);
    send(16'h1000, 16'h0C00, 1'b1);
    e = '{ex(Z, 16'h0400, 2'b01, 1'b0, 1'b1, 1'b0),
          ex(16'h0800, 16'h0C00, 2'b11, 1'b0, 1'b1, 1'b0),
          ex(16'h0800, 16'h0C00, 2'b11, 1'b0, 1'b1, 1'b0),
          ex(16'h0800, 16'h0C00, 2'b11, 1'b0, 1'b1, 1'b0),
          ex(16'h0800, 16'h0C00, 2'b11, 1'b0, 1'b1, 1'b0),
          ex(16'h1000, Z, 2'b10, 1'b0, 1'b1, 1'b0),
          ex(Z, Z, 2'b00, 1'b1, 1'b1, 1'b0),
          ex(Z, Z, 2'b00, 1'b0, 1'b0, 1'b1)};
    foreach (e[i]) begin
      if (obs !== e[i]) begin
        n_bad++; $display("FAIL stall step%0d: got %h want %h", i, obs, e[i]);
      end
      n_cmp++;
      stall = (i >= 1 && i <= 3);
      tick();
    end
    stall = 1'b0;
  endtask

  task automatic test_gaps_negative;
    logic [36:0] e[$];
    in_data = 32'hDEAD_BEEF;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (obs !== ex(Z, Z, 2'b00, 1'b0, 1'b0, 1'b1)) begin
        n_bad++; $display("FAIL gap_pre%0d: got %h want %h", k, obs, ex(Z, Z, 2'b00, 1'b0, 1'b0, 1'b1));
      end
      n_cmp++;
    end
    send(16'hE900, 16'hF300, 1'b0);
    for (int k = 0; k < 2; k++) begin
      if (obs !== ex(Z, Z, 2'b00, 1'b0, 1'b0, 1'b1)) begin
        n_bad++; $display("FAIL gap_mid%0d: got %h want %h", k, obs, ex(Z, Z, 2'b00, 1'b0, 1'b0, 1'b1));
      end
      n_cmp++;
      tick();
    end
    send(16'h0780, 16'h1080, 1'b1);
    e = '{ex(Z, 16'hF300, 2'b01, 1'b0, 1'b1, 1'b0),
          ex(16'hE900, 16'h1080, 2'b11, 1'b0, 1'b1, 1'b0),
          ex(16'h0780, Z, 2'b10, 1'b0, 1'b1, 1'b0),
          ex(Z, Z, 2'b00, 1'b1, 1'b1, 1'b0),
          ex(Z, Z, 2'b00, 1'b0, 1'b0, 1'b1)};
    foreach (e[i]) begin
      if (obs !== e[i]) begin
        n_bad++; $display("FAIL gaps step%0d: got %h want %h", i, obs, e[i]);
      end
      n_cmp++;
      tick();
    end
  endtask

  task automatic test_reset_midstream;
    logic [36:0] e[$];
    send(16'h0800, 16'h0400, 1'b0);
    send(16'h1000, 16'h0C00, 1'b1);
    tick();
    if (obs !== ex(16'h0800, 16'h0C00, 2'b11, 1'b0, 1'b1, 1'b0)) begin
      n_bad++; $display("FAIL rst_pre: got %h want %h", obs, ex(16'h0800, 16'h0C00, 2'b11, 1'b0, 1'b1, 1'b0));
    end
    n_cmp++;
    #2 rst = 1'b1;
    #1;
    if (obs !== ex(Z, Z, 2'b00, 1'b0, 1'b0, 1'b1)) begin
      n_bad++; $display("FAIL rst_async: got %h want %h", obs, ex(Z, Z, 2'b00, 1'b0, 1'b0, 1'b1));
    end
    n_cmp++;
    #1 rst = 1'b0;
    tick();
    send(16'h0200, 16'h0500, 1'b1);
    e = '{ex(Z, 16'h0500, 2'b01, 1'b0, 1'b1, 1'b0),
          ex(16'h0200, Z, 2'b10, 1'b0, 1'b1, 1'b0),
          ex(Z, Z, 2'b00, 1'b1, 1'b1, 1'b0),
          ex(Z, Z, 2'b00, 1'b0, 1'b0, 1'b1)};
    foreach (e[i]) begin
      if (obs !== e[i]) begin
        n_bad++; $display("FAIL rst_burst step%0d: got %h want %h", i, obs, e[i]);
      end
      n_cmp++;
      tick();
    end
  endtask

  task automatic test_single;
    logic [36:0] e[$];
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL single_idle_busy: got %b want 0", busy);
    end
    n_cmp++;
    send(16'h8000, 16'h7FFF, 1'b1);
    e = '{ex(Z, 16'h7FFF, 2'b01, 1'b0, 1'b1, 1'b0),
          ex(16'h8000, Z, 2'b10, 1'b0, 1'b1, 1'b0),
          ex(Z, Z, 2'b00, 1'b1, 1'b1, 1'b0),
          ex(Z, Z, 2'b00, 1'b0, 1'b0, 1'b1)};
    foreach (e[i]) begin
      if (obs !== e[i]) begin
        n_bad++; $display("FAIL single step%0d: got %h want %h", i, obs, e[i]);
      end
      n_cmp++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_stall();
    test_gaps_negative();
    test_reset_midstream();
    test_single();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
